regs_seq: RTL and testbench

REGS_SEQ -- requirements
Module: regs_seq

---
 rtl/regs_seq_pkg.sv | 24 ++
 rtl/regs_seq_if.sv | 35 +++
 rtl/regs_seq.sv | 119 +++++++++++
 tb/tb_regs_seq.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regs_seq_pkg.sv
// Shared types and constants for the register-file LOAD/DUMP sequencer.
// The register number type follows the register count.
package regs_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        SEND  = 2'd3
    } state_t;

    localparam logic OP_LOAD = 1'b0;
    localparam logic OP_DUMP = 1'b1;

    localparam int NREGS = 4;

    typedef logic [$clog2(NREGS)-1:0] rno_t;

    // True for the highest-numbered register, where a dump ends.
    function automatic logic is_last_reg(input rno_t rno);
        return rno == rno_t'(NREGS - 1);
    endfunction

endpackage

// File: rtl/regs_seq_if.sv
// Command, dump-stream, status and register-file signals of regs_seq.
// The sequencer uses the slave view; the environment uses the master view.
interface regs_seq_if #(
    parameter int N = 8
) ();

    logic                    cmd_valid;
    logic                    cmd_ready;
    logic                    cmd_op;
    regs_seq_pkg::rno_t      cmd_rno;
    logic [N-1:0]            cmd_data;

    logic                    out_valid;
    logic                    out_ready;
    logic [N-1:0]            out_data;
    regs_seq_pkg::rno_t      out_rno;

    logic                    busy;

    logic                    rf_w;
    regs_seq_pkg::rno_t      rf_Rdno;
    logic [N-1:0]            rf_Wdata;
    logic [N-1:0]            rf_Rd;

    modport slave (
        input  cmd_valid, cmd_op, cmd_rno, cmd_data, out_ready, rf_Rd,
        output cmd_ready, out_valid, out_data, out_rno, busy, rf_w, rf_Rdno, rf_Wdata
    );

    modport master (
        output cmd_valid, cmd_op, cmd_rno, cmd_data, out_ready, rf_Rd,
        input  cmd_ready, out_valid, out_data, out_rno, busy, rf_w, rf_Rdno, rf_Wdata
    );

endinterface

// File: rtl/regs_seq.sv
// Sequencer that writes single registers of an external register file (LOAD)
// or streams all of them out in order through a valid/ready port (DUMP).
module regs_seq
    import regs_seq_pkg::*;
#(
    parameter int n = 8
) (
    input  logic      clk,
    input  logic      reset,
    regs_seq_if.slave bus
);

    state_t         state;
    state_t         state_next;
    rno_t           index;
    rno_t           rdno;
    logic [n-1:0]   wdata;
    logic [n-1:0]   odata;
    rno_t           orno;
    logic           cmd_fire;
    logic           out_fire;

    assign cmd_fire = bus.cmd_valid && (state == IDLE);
    assign out_fire = (state == SEND) && bus.out_ready;

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every combinational output gets a default first so no path
    // through the case leaves it unassigned and infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (cmd_fire) begin
                    case (bus.cmd_op)
                        OP_LOAD: state_next = WRITE;
                        OP_DUMP: state_next = READ;
                        default: state_next = IDLE;
                    endcase
                end
            end
            WRITE:   state_next = IDLE;
            READ:    state_next = SEND;
            SEND: begin
                if (out_fire) begin
                    state_next = is_last_reg(index) ? IDLE : READ;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: command capture, read-data capture and dump index stepping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            index <= '0;
            rdno  <= '0;
            wdata <= '0;
            odata <= '0;
            orno  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_fire) begin
                        if (bus.cmd_op == OP_LOAD) begin
                            rdno  <= bus.cmd_rno;
                            wdata <= bus.cmd_data;
                        end else begin
                            index <= '0;
                            rdno  <= '0;
                        end
                    end
                end
                READ: begin
                    odata <= bus.rf_Rd;
                    orno  <= index;
                end
                SEND: begin
                    if (out_fire && !is_last_reg(index)) begin
                        index <= index + rno_t'(1);
                        rdno  <= index + rno_t'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Handshake and strobe outputs decode the state directly, so an
    // asynchronous reset drops them in the same cycle.
    always_comb begin
        bus.cmd_ready = 1'b0;
        bus.busy      = 1'b1;
        bus.rf_w      = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.cmd_ready = 1'b1;
                bus.busy      = 1'b0;
            end
            WRITE:   bus.rf_w      = 1'b1;
            SEND:    bus.out_valid = 1'b1;
            default: ;
        endcase
        bus.rf_Rdno  = rdno;
        bus.rf_Wdata = wdata;
        bus.out_data = odata;
        bus.out_rno  = orno;
    end

endmodule

// File: tb/tb_regs_seq.sv
// Self-checking bench for regs_seq with an attached 4-entry register file,
// directed LOAD/DUMP/stall/reset scenarios and a random LOAD/DUMP mix.
module tb_regs_seq;
    import regs_seq_pkg::*;

    localparam int W = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    regs_seq_if #(.N(W)) bus ();

    regs_seq #(.n(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // NOTE: register file storage has no reset; its contents survive the
    // sequencer's reset, which the mid-WRITE check relies on.
    logic [W-1:0] rf_mem [NREGS];
    always @(posedge clk) begin
        if (bus.rf_w) rf_mem[bus.rf_Rdno] <= bus.rf_Wdata;
    end
    assign bus.rf_Rd = rf_mem[bus.rf_Rdno];

    int           total  = 0;
    int           bad    = 0;
    int           cycles = 0;
    logic [W-1:0] model [NREGS];
    logic         load_pending = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cycles++;
    endtask

    // rf_w must be high exactly in the cycle after an accepted LOAD.
    always @(posedge clk or posedge reset) begin
        if (reset) load_pending <= 1'b0;
        else       load_pending <= bus.cmd_valid && bus.cmd_ready && (bus.cmd_op == OP_LOAD);
    end
    always @(negedge clk) begin
        if (!reset) check("rf_w_window", 32'(bus.rf_w), 32'(load_pending));
    end

    task automatic wait_ready(output int waited);
        waited = 0;
        while (!bus.cmd_ready && waited < 100) begin
            tick();
            waited++;
        end
        check("cmd_ready_timeout", 32'(bus.cmd_ready), 32'd1);
    endtask

    task automatic do_load(input rno_t rno, input logic [W-1:0] data);
        int waited;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_LOAD;
        bus.cmd_rno   = rno;
        bus.cmd_data  = data;
        wait_ready(waited);
        tick();
        bus.cmd_valid = 1'b0;
        model[rno]    = data;
    endtask

    // Issues a DUMP and collects the four words, optionally stalling one word,
    // randomizing out_ready, or holding a LOAD r1=FF on the command port.
    task automatic run_dump(input int stall_rno, input int stall_len, input bit rnd,
                            input bit hold_load, output int waited);
        logic [W-1:0] exp_w [NREGS];
        logic [W-1:0] old_r1;
        logic [W-1:0] pend_data;
        rno_t         pend_rno;
        logic         pend;
        int           got;
        int           held;
        int           budget;
        for (int i = 0; i < NREGS; i++) exp_w[i] = model[i];
        old_r1 = model[1];
        got = 0; held = 0; budget = 0; pend = 1'b0;
        pend_data = '0; pend_rno = '0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_DUMP;
        bus.cmd_rno   = rno_t'($urandom);
        bus.cmd_data  = W'($urandom);
        wait_ready(waited);
        tick();
        if (hold_load) begin
            bus.cmd_op   = OP_LOAD;
            bus.cmd_rno  = rno_t'(1);
            bus.cmd_data = 8'hFF;
        end else begin
            bus.cmd_valid = 1'b0;
        end
        while (got < NREGS && budget < 400) begin
            if (hold_load) check("hold_r1_unchanged", 32'(rf_mem[1]), 32'(old_r1));
            if (bus.out_valid) begin
                if (pend) begin
                    check("stall_data_stable", 32'(bus.out_data), 32'(pend_data));
                    check("stall_rno_stable", 32'(bus.out_rno), 32'(pend_rno));
                end
                if (int'(bus.out_rno) == stall_rno && held < stall_len) begin
                    check("stall_word_data", 32'(bus.out_data), 32'(exp_w[stall_rno]));
                    bus.out_ready = 1'b0;
                    held++;
                end else begin
                    bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                end
                if (bus.out_ready) begin
                    check("dump_rno", 32'(bus.out_rno), 32'(got));
                    check("dump_data", 32'(bus.out_data), 32'(exp_w[got]));
                    got++;
                    pend = 1'b0;
                end else begin
                    pend      = 1'b1;
                    pend_data = bus.out_data;
                    pend_rno  = bus.out_rno;
                end
            end else begin
                if (pend) check("stall_valid_held", 32'(bus.out_valid), 32'd1);
                pend = 1'b0;
                bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            tick();
            budget++;
        end
        check("dump_word_count", 32'(got), 32'(NREGS));
        check("dump_stall_len", 32'(held), 32'(stall_len));
        check("dump_ends_idle", 32'(bus.cmd_ready), 32'd1);
        bus.out_ready = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "simulation watchdog expired");
    end

    initial begin
        logic [W-1:0] exp27 [NREGS];
        int           w;
        int           pick;
        int           start;
        exp27[0] = 8'h11; exp27[1] = 8'h22; exp27[2] = 8'h33; exp27[3] = 8'h44;

        bus.cmd_valid = 1'b0;
        bus.cmd_op    = OP_LOAD;
        bus.cmd_rno   = '0;
        bus.cmd_data  = '0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (2) tick();
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_rf_w", 32'(bus.rf_w), 32'd0);
        check("rst_rf_Rdno", 32'(bus.rf_Rdno), 32'd0);
        check("rst_rf_Wdata", 32'(bus.rf_Wdata), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        check("rst_out_rno", 32'(bus.out_rno), 32'd0);
        reset = 1'b0;
        tick();

        // Single LOAD r2 = A5: one write cycle at T+1
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_LOAD;
        bus.cmd_rno   = rno_t'(2);
        bus.cmd_data  = 8'hA5;
        check("ld_rf_w_at_T", 32'(bus.rf_w), 32'd0);
        tick();
        bus.cmd_valid = 1'b0;
        model[2] = 8'hA5;
        check("ld_rf_w_T1", 32'(bus.rf_w), 32'd1);
        check("ld_rf_Rdno_T1", 32'(bus.rf_Rdno), 32'd2);
        check("ld_rf_Wdata_T1", 32'(bus.rf_Wdata), 32'hA5);
        check("ld_busy_T1", 32'(bus.busy), 32'd1);
        check("ld_cmd_ready_T1", 32'(bus.cmd_ready), 32'd0);
        tick();
        check("ld_rf_w_T2", 32'(bus.rf_w), 32'd0);
        check("ld_cmd_ready_T2", 32'(bus.cmd_ready), 32'd1);
        check("ld_r2_value", 32'(rf_mem[2]), 32'hA5);

        // Fill r0..r3, then dump with out_ready held high and check timing
        for (int i = 0; i < NREGS; i++) do_load(rno_t'(i), exp27[i]);
        tick();
        bus.out_ready = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_DUMP;
        bus.cmd_rno   = rno_t'(3);
        bus.cmd_data  = 8'hEE;
        for (int k = 0; k <= 10; k++) begin
            check("tm_out_valid", 32'(bus.out_valid), 32'(k == 2 || k == 4 || k == 6 || k == 8));
            check("tm_cmd_ready", 32'(bus.cmd_ready), 32'(k == 0 || k >= 9));
            if (bus.out_valid) begin
                check("tm_out_rno", 32'(bus.out_rno), 32'(k / 2 - 1));
                check("tm_out_data", 32'(bus.out_data), 32'(exp27[k / 2 - 1]));
            end
            tick();
            if (k == 0) bus.cmd_valid = 1'b0;
        end

        // Stall word 1 for five cycles
        run_dump(1, 5, 1'b0, 1'b0, w);

        // LOAD r1 = FF held on the port during a dump
        run_dump(-1, 0, 1'b0, 1'b1, w);
        tick();
        bus.cmd_valid = 1'b0;
        check("held_ld_rf_w", 32'(bus.rf_w), 32'd1);
        check("held_ld_rdno", 32'(bus.rf_Rdno), 32'd1);
        check("held_ld_wdata", 32'(bus.rf_Wdata), 32'hFF);
        model[1] = 8'hFF;
        tick();
        check("held_ld_r1", 32'(rf_mem[1]), 32'hFF);

        // LOAD immediately followed by DUMP
        do_load(rno_t'(3), 8'h77);
        run_dump(-1, 0, 1'b0, 1'b0, w);
        check("ld_dump_wait", 32'(w), 32'd1);

        // Reset in the middle of WRITE
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_LOAD;
        bus.cmd_rno   = rno_t'(3);
        bus.cmd_data  = 8'hC3;
        tick();
        bus.cmd_valid = 1'b0;
        check("mw_rf_w_before", 32'(bus.rf_w), 32'd1);
        #1 reset = 1'b1;
        #1;
        check("mw_rf_w", 32'(bus.rf_w), 32'd0);
        check("mw_rf_Wdata", 32'(bus.rf_Wdata), 32'd0);
        check("mw_rf_Rdno", 32'(bus.rf_Rdno), 32'd0);
        check("mw_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        tick();
        reset = 1'b0;
        check("mw_r3_kept", 32'(rf_mem[3]), 32'(model[3]));

        // Reset in the middle of SEND
        bus.out_ready = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_DUMP;
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        check("ms_out_valid_pre", 32'(bus.out_valid), 32'd1);
        check("ms_out_data_pre", 32'(bus.out_data), 32'(model[0]));
        #1 reset = 1'b1;
        #1;
        check("ms_out_valid", 32'(bus.out_valid), 32'd0);
        check("ms_busy", 32'(bus.busy), 32'd0);
        check("ms_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("ms_out_data", 32'(bus.out_data), 32'd0);
        check("ms_out_rno", 32'(bus.out_rno), 32'd0);
        tick();
        reset = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        check("ms_idle_after", 32'(bus.cmd_ready), 32'd1);

        // Random LOAD/DUMP mix against the array model
        start = cycles;
        while (cycles - start < 10000) begin
            pick = $urandom_range(0, 9);
            if (pick < 6) begin
                do_load(rno_t'($urandom), W'($urandom));
            end else if (pick < 8) begin
                run_dump(-1, 0, 1'b1, 1'b0, w);
            end else begin
                bus.cmd_valid = 1'b0;
                tick();
            end
        end
        bus.cmd_valid = 1'b0;
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
